piece_rng_arbiter: RTL

Shared tetromino generator that owns an 8-bit Galois LFSR (x^8+x^4+x^3+x^2+1: bit 7 feeds back into bits 0, 2, 3, 4) and advances it only when needed. It arbitrates two piece requesters round-robin: requester 0 is next-piece logic and requester 1 is the garbage/preview logic. It also rejection-samples a uniform piece ID 0..6 and applies a bounded no-repeat reroll. It sits between the game FSM and the random source, and replaces the free-running LFSR tap.

---
 rtl/piece_rng_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/piece_rng_arbiter.sv
// piece_rng_arbiter
//   Shared tetromino generator. Owns an 8-bit Galois LFSR
//   (x^8+x^4+x^3+x^2+1) that advances only when a piece is drawn, or
//   optionally on every idle cycle. Two requesters are served round-robin.
//   Each draw rejection-samples a uniform piece ID 0..6 and applies a
//   bounded no-repeat reroll.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i[1:0]   request level per requester (0 = next piece, 1 = garbage/preview)
//   seed_load_i  reseed pulse, honoured only in IDLE
//   seed_i[7:0]  reseed value (zero maps to 8'h01)
//   ack_o[1:0]   one-hot grant-complete pulse
//   piece_o[2:0] issued piece ID, held until the next issue
//   busy_o       high whenever the FSM is not in IDLE
//   lfsr_o[7:0]  current LFSR state (debug)
module piece_rng_arbiter #(
  parameter logic [7:0]  SEED       = 8'h5A,
  parameter int unsigned MAX_REROLL = 1,
  parameter bit          IDLE_STEP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       seed_load_i,
  input  logic [7:0] seed_i,
  output logic [1:0] ack_o,
  output logic [2:0] piece_o,
  output logic       busy_o,
  output logic [7:0] lfsr_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    EVAL = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic [1:0] MaxReroll = 2'(MAX_REROLL);
  localparam logic [2:0] NoPiece   = 3'd7;

  // An all-zero LFSR would lock up, so zero seeds are remapped.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  // Galois step: bit 7 shifts out and is folded back into bits 0, 2, 3, 4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
  endfunction

  state_e     state_q;
  logic [7:0] lfsr_q;
  logic [2:0] last_q;
  logic       rr_q;
  logic       grant_q;
  logic [1:0] reroll_q;
  logic [1:0] ack_q;
  logic [2:0] piece_q;
  logic       busy_q;

  logic [7:0] lfsr_d;
  logic [2:0] cand;
  logic       grant_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    cand   = lfsr_q[2:0];
    // Single requester wins outright; a tie goes to the rr pointer.
    if (req_i == 2'b11) grant_d = rr_q;
    else                grant_d = req_i[1];
  end

  // NOTE: every register here is updated with <= so all state moves
  // together on the edge; blocking assignments would create ordering races.
  // NOTE: all registers are small flops, so each one gets an explicit
  // async reset value; nothing is left to power-up state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= fix_seed(SEED);
      last_q   <= NoPiece;
      rr_q     <= 1'b0;
      grant_q  <= 1'b0;
      reroll_q <= 2'd0;
      ack_q    <= 2'b00;
      piece_q  <= 3'd0;
      busy_q   <= 1'b0;
    end else begin
      // ack is a single-cycle pulse; only the ACK state raises it.
      ack_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (seed_load_i) begin
            // Reseed takes priority; requests wait for the next cycle.
            lfsr_q <= fix_seed(seed_i);
          end else if (req_i != 2'b00) begin
            grant_q  <= grant_d;
            reroll_q <= 2'd0;
            state_q  <= STEP;
            busy_q   <= 1'b1;
          end else if (IDLE_STEP) begin
            lfsr_q <= lfsr_d;
          end
        end
        STEP: begin
          lfsr_q  <= lfsr_d;
          state_q <= EVAL;
        end
        EVAL: begin
          if (cand == NoPiece) begin
            // Rejection sampling: 7 is not a piece and costs no reroll.
            state_q <= STEP;
          end else if (cand == last_q && reroll_q < MaxReroll) begin
            reroll_q <= reroll_q + 2'd1;
            state_q  <= STEP;
          end else begin
            last_q  <= cand;
            rr_q    <= ~grant_q;
            state_q <= ACK;
          end
        end
        ACK: begin
          ack_q   <= grant_q ? 2'b10 : 2'b01;
          piece_q <= last_q;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign piece_o = piece_q;
  assign busy_o  = busy_q;
  assign lfsr_o  = lfsr_q;

endmodule
